// File: rtl/regset_writeback.sv
// Regset write-port front end: load FIFO (priority) merged with ALU results into a registered write stage.
// Optional hazard check enabled by defining WRITEBACK_HAZARD_EN.
`ifndef REGISTER_COUNT
`define REGISTER_COUNT 32
`endif

module regset_writeback #(
  parameter int RegisterCount = `REGISTER_COUNT,
  parameter int LoadFifoDepth = 4,
  localparam int RW = $clog2(RegisterCount),
  localparam int PW = $clog2(LoadFifoDepth),
  localparam int CW = PW + 1,
  localparam int WW = 32
) (
  input  logic          clk,
  input  logic          res,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [RW-1:0] alu_reg,
  input  logic [WW-1:0] alu_data,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [RW-1:0] load_reg,
  input  logic [WW-1:0] load_data,
  output logic [WW-1:0] write,
  output logic [RW-1:0] write_reg,
  output logic          write_enable,
  input  logic [RW-1:0] hz_reg0,
  input  logic [RW-1:0] hz_reg1,
  output logic          hz_stall,
  output logic [CW-1:0] fifo_count
);

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [WW-1:0] data;
  } entry_t;

  entry_t [LoadFifoDepth-1:0] mem_q, mem_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [WW-1:0] wdata_q, wdata_d;
  logic [RW-1:0] wreg_q, wreg_d;

  logic empty, full, alu_hs, load_hs, push, pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(LoadFifoDepth));
  // Readies are forced low while reset is asserted, not just after the next edge.
  assign load_ready = res && !full;
  assign alu_ready  = res && empty;
  assign alu_hs     = alu_valid && alu_ready;
  assign load_hs    = load_valid && load_ready;
  assign push       = load_hs && (load_reg != '0);
  assign pop        = !empty;

  assign write        = wdata_q;
  assign write_reg    = wreg_q;
  assign write_enable = we_q;
  assign fifo_count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    wreg_d   = wreg_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: load_reg, data: load_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      we_d     = 1'b1;
      wdata_d  = mem_q[rd_ptr_q].data;
      wreg_d   = mem_q[rd_ptr_q].rd;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (alu_hs && alu_reg != '0) begin
      we_d    = 1'b1;
      wdata_d = alu_data;
      wreg_d  = alu_reg;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wreg_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wreg_q   <= wreg_d;
    end
  end

`ifdef WRITEBACK_HAZARD_EN
  logic [LoadFifoDepth-1:0] ent_vld;
  logic hit0, hit1;

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < LoadFifoDepth; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rd_ptr_q;
    assign ent_vld[i] = {1'b0, off} < count_q;
  end

  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < LoadFifoDepth; i++) begin
      if (ent_vld[i] && mem_q[i].rd == hz_reg0) hit0 = 1'b1;
      if (ent_vld[i] && mem_q[i].rd == hz_reg1) hit1 = 1'b1;
    end
    if (we_q && wreg_q == hz_reg0) hit0 = 1'b1;
    if (we_q && wreg_q == hz_reg1) hit1 = 1'b1;
    if (alu_hs && alu_reg == hz_reg0) hit0 = 1'b1;
    if (alu_hs && alu_reg == hz_reg1) hit1 = 1'b1;
    if (load_hs && load_reg == hz_reg0) hit0 = 1'b1;
    if (load_hs && load_reg == hz_reg1) hit1 = 1'b1;
  end

  assign hz_stall = (hit0 && hz_reg0 != '0) || (hit1 && hz_reg1 != '0);
`else
  logic unused_hz;
  assign unused_hz = ^{hz_reg0, hz_reg1};
  assign hz_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_regset_writeback.sv
// Bench for regset_writeback: directed steps then random traffic against a queue-based reference model.
module tb_regset_writeback;
  localparam int D  = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          alu_valid = 1'b0, load_valid = 1'b0;
  logic          alu_ready, load_ready;
  logic [RW-1:0] alu_reg = '0, load_reg = '0, hz_reg0 = '0, hz_reg1 = '0;
  logic [31:0]   alu_data = '0, load_data = '0;
  logic [31:0]   write;
  logic [RW-1:0] write_reg;
  logic          write_enable, hz_stall;
  logic [2:0]    fifo_count;

  regset_writeback dut (
    .clk(clk), .res(res),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_reg(load_reg), .load_data(load_data),
    .write(write), .write_reg(write_reg), .write_enable(write_enable),
    .hz_reg0(hz_reg0), .hz_reg1(hz_reg1), .hz_stall(hz_stall), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] r;
    logic [31:0]   d;
  } ent_t;

  ent_t          q[$];
  logic          exp_we = 1'b0;
  logic [31:0]   exp_wd = '0;
  logic [RW-1:0] exp_wr = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A source register has a pending write if anything queued, staged or being accepted targets it.
  function automatic bit pending(input logic [RW-1:0] r);
    bit p = 0;
    if (r == 0) return 0;
    foreach (q[i]) if (q[i].r == r) p = 1;
    if (exp_we && exp_wr == r) p = 1;
    if (alu_valid && q.size() == 0 && alu_reg == r) p = 1;
    if (load_valid && q.size() < D && load_reg == r) p = 1;
    return p;
  endfunction

  function automatic bit exp_hz();
`ifdef WRITEBACK_HAZARD_EN
    return pending(hz_reg0) || pending(hz_reg1);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    exp_we = 0;
    exp_wd = '0;
    exp_wr = '0;
  endtask

  // One clock: check readies/hazard before the edge, advance the model, check outputs after it.
  task automatic cycle(output bit la, output bit aa);
    bit lr, ar;
    ent_t e;
    #1;
    lr = q.size() < D;
    ar = q.size() == 0;
    chk("load_ready", 32'(load_ready), 32'(lr));
    chk("alu_ready", 32'(alu_ready), 32'(ar));
    chk("hz_stall", 32'(hz_stall), 32'(exp_hz()));
    la = load_valid && lr;
    aa = alu_valid && ar;
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = 1; exp_wd = e.d; exp_wr = e.r;
    end else if (aa && alu_reg != 0) begin
      exp_we = 1; exp_wd = alu_data; exp_wr = alu_reg;
    end else begin
      exp_we = 0;
    end
    if (la && load_reg != 0) q.push_back('{r: load_reg, d: load_data});
    #1;
    chk("write_enable", 32'(write_enable), 32'(exp_we));
    chk("write", write, exp_wd);
    chk("write_reg", 32'(write_reg), 32'(exp_wr));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    @(negedge clk);
  endtask

  initial begin
    bit la, aa;
    bit got;

    // reset state
    #3;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_write", write, 32'd0);
    chk("rst_wreg", 32'(write_reg), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_lrdy", 32'(load_ready), 32'd0);
    chk("rst_ardy", 32'(alu_ready), 32'd0);
    chk("rst_hz", 32'(hz_stall), 32'd0);
    @(negedge clk);
    res = 1'b1;

    // single ALU write
    alu_valid = 1; alu_reg = 5'd1; alu_data = 32'd42;
    cycle(la, aa);
    chk("alu1_hs", 32'(aa), 32'd1);
    chk("alu1_we", 32'(write_enable), 32'd1);
    chk("alu1_wreg", 32'(write_reg), 32'd1);
    chk("alu1_write", write, 32'd42);
    alu_valid = 0;
    cycle(la, aa);
    chk("alu1_hold", write, 32'd42);

    // load priority over ALU
    load_valid = 1; load_reg = 5'd2; load_data = 32'd69;
    cycle(la, aa);
    load_valid = 0;
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'd7;
    cycle(la, aa);
    chk("prio_alu_blocked", 32'(aa), 32'd0);
    chk("prio_first", write, 32'd69);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle(la, aa);
      got = aa;
    end
    chk("prio_alu_taken", 32'(got), 32'd1);
    chk("prio_second", write, 32'd7);
    alu_valid = 0;

    // back-to-back loads
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_reg = 5'(10 + i); load_data = 32'(100 + i);
      cycle(la, aa);
    end
    load_valid = 0;
    for (int i = 0; i < 3; i++) cycle(la, aa);
    chk("loads_drained", 32'(fifo_count), 32'd0);

    // zero register on both sources
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'd37;
    load_valid = 1; load_reg = 5'd0; load_data = 32'd37;
    cycle(la, aa);
    chk("x0_alu_hs", 32'(aa), 32'd1);
    chk("x0_load_hs", 32'(la), 32'd1);
    alu_valid = 0; load_valid = 0;
    cycle(la, aa);
    chk("x0_no_we", 32'(write_enable), 32'd0);

    // hazard on a queued load
    hz_reg0 = 5'd5; hz_reg1 = 5'd0;
    load_valid = 1; load_reg = 5'd5; load_data = 32'hdead;
    alu_valid = 1; alu_reg = 5'd6; alu_data = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      cycle(la, aa);
      if (la) load_valid = 0;
      if (aa) alu_valid = 0;
    end
    load_valid = 0; alu_valid = 0;

    // reset mid-stream
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_reg = 5'(20 + i); load_data = 32'(200 + i);
      cycle(la, aa);
    end
    #2;
    res = 1'b0;
    #1;
    model_reset();
    chk("mrst_we", 32'(write_enable), 32'd0);
    chk("mrst_count", 32'(fifo_count), 32'd0);
    chk("mrst_lrdy", 32'(load_ready), 32'd0);
    chk("mrst_hz", 32'(hz_stall), 32'd0);
    load_valid = 0;
    @(posedge clk);
    #1;
    chk("mrst_we_edge", 32'(write_enable), 32'd0);
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 3; i++) cycle(la, aa);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (!load_valid && $urandom_range(0, 2) != 0) begin
        load_valid = 1; load_reg = 5'($urandom_range(0, 7)); load_data = $urandom;
      end
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1; alu_reg = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      hz_reg0 = 5'($urandom_range(0, 7));
      hz_reg1 = 5'($urandom_range(0, 7));
      cycle(la, aa);
      if (la) load_valid = 0;
      if (aa) alu_valid = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
